// File: rtl/calc_text_renderer.sv
`default_nettype none
// ============================================================================
// calc_text_renderer: one-row character buffer mapped onto VGA scan cells,
// glyph-generator drive and 2-tick pixel/sync pipeline; buffer updates are
// deferred to vertical blanking. Optional blinking cursor: TEXT_CURSOR_EN.
// Revision: 1.0
// ============================================================================
module calc_text_renderer #(
    parameter int COLS         = 16,
    parameter int ORIGIN_X     = 64,
    parameter int ORIGIN_Y     = 224,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_en,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    video_on,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(COLS)-1:0] wr_addr,
    input  logic [7:0]              wr_char,
    input  logic                    clear_req,
    output logic                    clear_busy,
    input  logic [$clog2(COLS)-1:0] cursor_pos,
    output logic [7:0]              ascii_code,
    output logic [4:0]              char_x,
    output logic [4:0]              char_y,
    input  logic                    glyph_pixel,
    output logic                    pixel_on,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    video_on_out
);
    localparam int          AW      = $clog2(COLS);
    localparam logic [10:0] C_X0    = 11'(ORIGIN_X);
    localparam logic [10:0] C_X_END = 11'(ORIGIN_X + 32 * COLS);
    localparam logic [10:0] C_Y0    = 11'(ORIGIN_Y);
    localparam logic [10:0] C_Y_END = 11'(ORIGIN_Y + 32);
    localparam logic [9:0]  C_VACT  = 10'(V_ACTIVE);
    localparam logic [7:0]  C_SPACE = 8'd32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t       r_state;
    logic [AW-1:0] r_cnt;
    logic          r_clear_pend;
    logic [7:0]    r_buf [COLS];

    logic          r_in_win;
    logic [AW-1:0] r_cell;
    logic          r_hs_s1;
    logic          r_vs_s1;
    logic          r_vid_s1;

    logic [9:0] w_xo;
    logic [9:0] w_yo;
    logic       w_in_win;
    logic       w_vblank;
    logic       w_cursor_hit;

    assign w_xo     = x - 10'(ORIGIN_X);
    assign w_yo     = y - 10'(ORIGIN_Y);
    assign w_in_win = ({1'b0, x} >= C_X0) && ({1'b0, x} < C_X_END) &&
                      ({1'b0, y} >= C_Y0) && ({1'b0, y} < C_Y_END);
    assign w_vblank = (y >= C_VACT);

    assign wr_ready   = rst_n && (r_state == ST_IDLE) && w_vblank && !r_clear_pend;
    assign clear_busy = r_clear_pend || (r_state == ST_CLEAR);
    assign ascii_code = r_in_win ? r_buf[r_cell] : 8'd0;

    // Write/clear scheduler; the buffer only ever changes here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_clear_pend <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                r_buf[i] <= C_SPACE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wr_valid && wr_ready) begin
                        r_buf[wr_addr] <= wr_char;
                    end
                    if (clear_req) begin
                        r_clear_pend <= 1'b1;
                    end
                    if (r_clear_pend && w_vblank) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_buf[r_cnt] <= C_SPACE;
                    if (r_cnt == AW'(COLS - 1)) begin
                        r_state      <= ST_IDLE;
                        r_clear_pend <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_win <= 1'b0;
            r_cell   <= '0;
            char_x   <= '0;
            char_y   <= '0;
            r_hs_s1  <= 1'b0;
            r_vs_s1  <= 1'b0;
            r_vid_s1 <= 1'b0;
        end else if (pix_en) begin
            r_in_win <= w_in_win;
            r_cell   <= w_xo[5 +: AW];
            char_x   <= w_xo[4:0];
            char_y   <= w_yo[4:0];
            r_hs_s1  <= hsync_in;
            r_vs_s1  <= vsync_in;
            r_vid_s1 <= video_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on     <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            video_on_out <= 1'b0;
        end else if (pix_en) begin
            pixel_on     <= (glyph_pixel & r_in_win & r_vid_s1) | w_cursor_hit;
            hsync_out    <= r_hs_s1;
            vsync_out    <= r_vs_s1;
            video_on_out <= r_vid_s1;
        end
    end

`ifdef TEXT_CURSOR_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] r_frame;
    logic          r_blink;
    logic          r_vs_prev;

    // Frames are counted on raw vsync rising edges, independent of pix_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame   <= '0;
            r_blink   <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            if (vsync_in && !r_vs_prev) begin
                if (r_frame == BW'(BLINK_FRAMES - 1)) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    assign w_cursor_hit = r_in_win && (r_cell == cursor_pos) &&
                          (char_y >= 5'd29) && r_blink;

    logic w_unused;
    assign w_unused = ^{w_xo, w_yo};
`else
    assign w_cursor_hit = 1'b0;

    logic w_unused;
    assign w_unused = ^{w_xo, w_yo, cursor_pos};
`endif

endmodule
`default_nettype wire
